zaq_bus_sequencer: RTL and testbench
====================================

# zaq_bus_sequencer

Two-requester arbiter and access sequencer for the 5-bit-addressed zaq register bank bus (wrb/rdb strobes, 64-bit din with dual-word write, 32-bit dout). It sits between the host interface and the local service engine and the register bank. It serializes their accesses with round-robin fairness. It generates address setup, strobe width and hold phases so that the bank sees glitch-free, single-owner transactions.

## Interface
- SETUP_CYCLES, 1, cycles address/data are stable before strobe (0..7; 0 skips SETUP)
- STROBE_CYCLES, 2, cycles wrb/rdb held low (1..15)
- sysclk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- a_req / b_req  in  1  requester A/B access request, held until ack
- a_we / b_we  in  1  1 = write, 0 = read
- a_dbl / b_dbl  in  1  dual-word write (drives bus_n9_bit_write); ignored on reads
- a_addr / b_addr  in  5  register address
- a_wdata / b_wdata  in  64  write data ([31:0] word 0, [63:32] word 1)
- a_ack / b_ack  out  1  one-cycle completion pulse
- a_rdata / b_rdata  out  32  read data, valid from ack until next ack to same requester
- bus_wrb  out  1  write strobe, active-low
- bus_rdb  out  1  read strobe, active-low
- bus_addr  out  5  register address to bank
- bus_din  out  64  write data to bank
- bus_n9_bit_write  out  1  dual-word write qualifier
- bus_dout  in  32  read data from bank
- busy  out  1  1 whenever state != IDLE
- grant_b  out  1  owner of current/last transaction (0 = A, 1 = B)

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: sample a_req/b_req. If only one is set, grant it. If both are set, grant the one not served last (last_owner). On grant, latch addr/we/dbl/wdata into bus registers. Go to SETUP, or to STROBE if SETUP_CYCLES = 0.
- SETUP: strobes high; count SETUP_CYCLES, then go to STROBE.
- STROBE: bus_wrb low (we = 1) or bus_rdb low (we = 0) for exactly STROBE_CYCLES cycles. For reads, capture bus_dout into the owner's rdata on the edge that ends the last strobe cycle.
- HOLD: strobes high; address/data unchanged; owner's ack = 1 for this single cycle. Update last_owner. Return to IDLE.
- bus_n9_bit_write = latched dbl AND we. It is 0 for reads.
- bus_addr/bus_din hold their last value in IDLE. Change only on grant.
- Requester may keep req high after ack. It is re-arbitrated in the next IDLE cycle, and the other requester wins if it is pending.
- Invariant: bus_wrb and bus_rdb never both low. The strobes are registered outputs and do not glitch.
- Requests dropped before ack are illegal. The transaction still completes, and ack is still pulsed.
- Reset values: state IDLE, bus_wrb = 1, bus_rdb = 1, bus_addr = 0, bus_din = 0, bus_n9_bit_write = 0, a_ack = b_ack = 0, a_rdata = b_rdata = 0, busy = 0, grant_b = 1 (last_owner = B, so A wins the first tie).
- Reset mid-transaction: strobes go high asynchronously. The transaction is aborted and no ack is issued.

## Timing
- Defaults: req seen at edge 0, then SETUP in cycle 1, STROBE in cycles 2–3, HOLD with ack in cycle 4, IDLE in cycle 5.
- Request-to-ack latency = 1 + SETUP_CYCLES + STROBE_CYCLES edges.
- Back-to-back throughput: one transaction per SETUP_CYCLES + STROBE_CYCLES + 2 cycles, including one IDLE cycle.
- Read data is sampled at the end of the last strobe cycle. The bank must present dout within STROBE_CYCLES cycles of rdb falling.
- Phase counter is 4 bits, loaded on state entry. It does not wrap.

## Structure
- Shared package zaq_bus_pkg:
  - state enum
  - register address constants (klim 0x00 … main_reset_hold 0x17), shared with the bank and with software headers
  - ranges for SETUP_CYCLES and STROBE_CYCLES
- Sub-module rr_arb2: two-way round-robin with last_owner register and grant/update inputs.
- FSM, counter and bus registers stay in the top level.

## Test plan
- Single read by A of address 0x0A with bus_dout = 0x1234_5678 -> rdb low in cycles 2–3 only, a_ack in cycle 4, a_rdata = 0x1234_5678, b_ack stays 0.
- Dual write by B to address 0x02 with wdata = 0xAAAA_AAAA_5555_5555, dbl = 1 -> bus_n9_bit_write = 1, bus_din matches during wrb low, b_ack once.
- A and B request together continuously for 4 transactions -> grants alternate A, B, A, B; one IDLE cycle between; wrb and rdb never both low.
- SETUP_CYCLES = 0, STROBE_CYCLES = 1 -> ack 2 edges after req; strobe exactly one cycle wide.
- Reset asserted mid-STROBE of a write -> wrb high immediately; no ack; all outputs at reset values; first tie after reset is granted to A.
- Read with dbl = 1 -> bus_n9_bit_write stays 0; rdata captured normally.

Source files
------------

// File: rtl/zaq_bus_sequencer_pkg.sv
// ---- zaq_bus_pkg : shared states, register map and timing ranges for the zaq bus -- rev 1.0 ----
`default_nettype none

package zaq_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Register map anchors shared with the bank RTL and the software headers
  localparam logic [4:0] REG_KLIM            = 5'h00;
  localparam logic [4:0] REG_MAIN_RESET_HOLD = 5'h17;

  localparam int SETUP_CYCLES_MIN  = 0;
  localparam int SETUP_CYCLES_MAX  = 7;
  localparam int STROBE_CYCLES_MIN = 1;
  localparam int STROBE_CYCLES_MAX = 15;

  // Phase counter counts down to zero, so a phase of N cycles loads N-1
  function automatic logic [3:0] phase_load(input int cycles);
    if (cycles < 1) return 4'd0;
    return 4'(cycles - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/zaq_bus_sequencer_if.sv
// ---- zaq_bus_sequencer_if : requester handshakes and register-bank bus -- rev 1.0 ----
`default_nettype none

interface zaq_bus_sequencer_if;

  logic        a_req, b_req;
  logic        a_we, b_we;
  logic        a_dbl, b_dbl;
  logic [4:0]  a_addr, b_addr;
  logic [63:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata;

  logic        bus_wrb;
  logic        bus_rdb;
  logic [4:0]  bus_addr;
  logic [63:0] bus_din;
  logic        bus_n9_bit_write;
  logic [31:0] bus_dout;

  logic        busy;
  logic        grant_b;

  // The sequencer is the slave of the requesters and drives the bank bus
  modport slave (
    input  a_req, b_req, a_we, b_we, a_dbl, b_dbl, a_addr, b_addr, a_wdata, b_wdata, bus_dout,
    output a_ack, b_ack, a_rdata, b_rdata,
    output bus_wrb, bus_rdb, bus_addr, bus_din, bus_n9_bit_write, busy, grant_b
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_dbl, b_dbl, a_addr, b_addr, a_wdata, b_wdata, bus_dout,
    input  a_ack, b_ack, a_rdata, b_rdata,
    input  bus_wrb, bus_rdb, bus_addr, bus_din, bus_n9_bit_write, busy, grant_b
  );

endinterface

`default_nettype wire

// File: rtl/zaq_bus_sequencer_rr_arb2.sv
// ---- rr_arb2 : two-way round-robin arbiter with last-owner memory -- rev 1.0 ----
`default_nettype none

module rr_arb2
  import zaq_bus_pkg::*;
(
  input  logic sysclk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  input  logic served_b,
  output logic gnt_valid,
  output logic gnt_b
);

  logic last_owner;

  // Resetting to B means A wins the first tie
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      last_owner <= 1'b1;
    end else if (update) begin
      last_owner <= served_b;
    end
  end

  assign gnt_valid = req_a | req_b;
  assign gnt_b     = req_b & (~req_a | ~last_owner);

endmodule

`default_nettype wire

// File: rtl/zaq_bus_sequencer.sv
// ---- zaq_bus_sequencer : arbitrates two requesters onto the zaq register bank bus -- rev 1.0 ----
`default_nettype none

module zaq_bus_sequencer
  import zaq_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                sysclk,
  input  logic                reset,
  zaq_bus_sequencer_if.slave  sif
);

  localparam logic [3:0] SETUP_LOAD  = phase_load(
    (SETUP_CYCLES > SETUP_CYCLES_MAX) ? SETUP_CYCLES_MAX : SETUP_CYCLES);
  localparam logic [3:0] STROBE_LOAD = phase_load(
    (STROBE_CYCLES > STROBE_CYCLES_MAX) ? STROBE_CYCLES_MAX : STROBE_CYCLES);

  state_t      state;
  logic [3:0]  phase;
  logic        owner_b;
  logic        we_q;
  logic        wrb, rdb, n9;
  logic [4:0]  addr;
  logic [63:0] din;
  logic        a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata;

  logic        gnt_valid, gnt_b;
  logic        sel_we, sel_dbl;
  logic [4:0]  sel_addr;
  logic [63:0] sel_wdata;

  rr_arb2 u_arb (
    .sysclk    (sysclk),
    .reset     (reset),
    .req_a     (sif.a_req),
    .req_b     (sif.b_req),
    .update    (state == ST_HOLD),
    .served_b  (owner_b),
    .gnt_valid (gnt_valid),
    .gnt_b     (gnt_b)
  );

  assign sel_we    = gnt_b ? sif.b_we    : sif.a_we;
  assign sel_dbl   = gnt_b ? sif.b_dbl   : sif.a_dbl;
  assign sel_addr  = gnt_b ? sif.b_addr  : sif.a_addr;
  assign sel_wdata = gnt_b ? sif.b_wdata : sif.a_wdata;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      phase   <= 4'd0;
      owner_b <= 1'b1;
      we_q    <= 1'b0;
      wrb     <= 1'b1;
      rdb     <= 1'b1;
      n9      <= 1'b0;
      addr    <= 5'd0;
      din     <= 64'd0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= 32'd0;
      b_rdata <= 32'd0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_b <= gnt_b;
            we_q    <= sel_we;
            addr    <= sel_addr;
            din     <= sel_wdata;
            n9      <= sel_we & sel_dbl;
            if (SETUP_CYCLES == 0) begin
              state <= ST_STROBE;
              phase <= STROBE_LOAD;
              wrb   <= ~sel_we;
              rdb   <= sel_we;
            end else begin
              state <= ST_SETUP;
              phase <= SETUP_LOAD;
            end
          end
        end
        ST_SETUP: begin
          if (phase == 4'd0) begin
            state <= ST_STROBE;
            phase <= STROBE_LOAD;
            wrb   <= ~we_q;
            rdb   <= we_q;
          end else begin
            phase <= phase - 4'd1;
          end
        end
        ST_STROBE: begin
          if (phase == 4'd0) begin
            state <= ST_HOLD;
            wrb   <= 1'b1;
            rdb   <= 1'b1;
            // Read data is taken on the edge that closes the final strobe cycle
            if (owner_b) begin
              b_ack <= 1'b1;
              if (!we_q) b_rdata <= sif.bus_dout;
            end else begin
              a_ack <= 1'b1;
              if (!we_q) a_rdata <= sif.bus_dout;
            end
          end else begin
            phase <= phase - 4'd1;
          end
        end
        ST_HOLD: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sif.bus_wrb          = wrb;
  assign sif.bus_rdb          = rdb;
  assign sif.bus_addr         = addr;
  assign sif.bus_din          = din;
  assign sif.bus_n9_bit_write = n9;
  assign sif.a_ack            = a_ack;
  assign sif.b_ack            = b_ack;
  assign sif.a_rdata          = a_rdata;
  assign sif.b_rdata          = b_rdata;
  assign sif.busy             = (state != ST_IDLE);
  assign sif.grant_b          = owner_b;

endmodule

`default_nettype wire

// File: tb/tb_zaq_bus_sequencer.sv
// ---- tb_zaq_bus_sequencer : directed vectors against default and fast-timing sequencers -- rev 1.0 ----
`default_nettype none

module tb_zaq_bus_sequencer;
  import zaq_bus_pkg::*;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        sel    = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0, a_dbl = 1'b0, b_dbl = 1'b0;
  logic [4:0]  a_addr = 5'd0, b_addr = 5'd0;
  logic [63:0] a_wdata = 64'd0, b_wdata = 64'd0;
  logic [31:0] bus_dout = 32'd0;

  zaq_bus_sequencer_if bus0 ();
  zaq_bus_sequencer_if bus1 ();

  assign bus0.a_req = a_req & ~sel;
  assign bus1.a_req = a_req & sel;
  assign bus0.b_req = b_req & ~sel;
  assign bus1.b_req = b_req & sel;
  assign {bus0.a_we, bus1.a_we}         = {2{a_we}};
  assign {bus0.b_we, bus1.b_we}         = {2{b_we}};
  assign {bus0.a_dbl, bus1.a_dbl}       = {2{a_dbl}};
  assign {bus0.b_dbl, bus1.b_dbl}       = {2{b_dbl}};
  assign {bus0.a_addr, bus1.a_addr}     = {2{a_addr}};
  assign {bus0.b_addr, bus1.b_addr}     = {2{b_addr}};
  assign {bus0.a_wdata, bus1.a_wdata}   = {2{a_wdata}};
  assign {bus0.b_wdata, bus1.b_wdata}   = {2{b_wdata}};
  assign {bus0.bus_dout, bus1.bus_dout} = {2{bus_dout}};

  zaq_bus_sequencer #(.SETUP_CYCLES(1), .STROBE_CYCLES(2)) dut0 (
    .sysclk (sysclk), .reset (reset), .sif (bus0)
  );
  zaq_bus_sequencer #(.SETUP_CYCLES(0), .STROBE_CYCLES(1)) dut1 (
    .sysclk (sysclk), .reset (reset), .sif (bus1)
  );

  always #5 sysclk = ~sysclk;

  logic        o_wrb, o_rdb, o_n9, o_aack, o_back, o_busy, o_gb;
  logic [4:0]  o_addr;
  logic [63:0] o_din;
  logic [31:0] o_ard, o_brd;
  assign o_wrb  = sel ? bus1.bus_wrb          : bus0.bus_wrb;
  assign o_rdb  = sel ? bus1.bus_rdb          : bus0.bus_rdb;
  assign o_n9   = sel ? bus1.bus_n9_bit_write : bus0.bus_n9_bit_write;
  assign o_aack = sel ? bus1.a_ack            : bus0.a_ack;
  assign o_back = sel ? bus1.b_ack            : bus0.b_ack;
  assign o_busy = sel ? bus1.busy             : bus0.busy;
  assign o_gb   = sel ? bus1.grant_b          : bus0.grant_b;
  assign o_addr = sel ? bus1.bus_addr         : bus0.bus_addr;
  assign o_din  = sel ? bus1.bus_din          : bus0.bus_din;
  assign o_ard  = sel ? bus1.a_rdata          : bus0.a_rdata;
  assign o_brd  = sel ? bus1.b_rdata          : bus0.b_rdata;

  int   checks = 0;
  int   errors = 0;
  logic overlap_seen = 1'b0;

  always @(negedge sysclk) begin
    if ((!bus0.bus_wrb && !bus0.bus_rdb) || (!bus1.bus_wrb && !bus1.bus_rdb)) overlap_seen = 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        who_b;
    logic        we;
    logic        dbl;
    logic [4:0]  addr;
    logic [63:0] wdata;
    logic [31:0] dout;
    logic        exp_n9;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] mod_rd [2][2];

  // Cycle c (bit c of each mask) is the cycle after edge c-1, edge 0 being the one that sees req
  task automatic observe(input int ncyc,
                         output logic [15:0] rdb_m, output logic [15:0] wrb_m,
                         output logic [15:0] acka_m, output logic [15:0] ackb_m,
                         output logic [4:0] addr_s, output logic [63:0] din_s, output logic n9_s);
    logic seen = 1'b0;
    rdb_m = '0; wrb_m = '0; acka_m = '0; ackb_m = '0;
    addr_s = '0; din_s = '0; n9_s = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      rdb_m[c]  = ~o_rdb;
      wrb_m[c]  = ~o_wrb;
      acka_m[c] = o_aack;
      ackb_m[c] = o_back;
      if (!seen && (!o_rdb || !o_wrb)) begin
        seen = 1'b1; addr_s = o_addr; din_s = o_din; n9_s = o_n9;
      end
      if (o_aack) a_req = 1'b0;
      if (o_back) b_req = 1'b0;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v, input int ncyc,
                         input logic [15:0] exp_stb, input logic [15:0] exp_ack);
    logic [15:0] rdb_m, wrb_m, acka_m, ackb_m;
    logic [4:0]  addr_s;
    logic [63:0] din_s;
    logic        n9_s;
    a_we = v.we; b_we = v.we; a_dbl = v.dbl; b_dbl = v.dbl;
    a_addr = v.addr; b_addr = v.addr; a_wdata = v.wdata; b_wdata = v.wdata;
    bus_dout = v.dout;
    if (v.who_b) b_req = 1'b1;
    else         a_req = 1'b1;
    observe(ncyc, rdb_m, wrb_m, acka_m, ackb_m, addr_s, din_s, n9_s);
    if (!v.we) mod_rd[sel][v.who_b] = v.dout;
    check($sformatf("v%0d_strobe", idx),    v.we ? wrb_m : rdb_m, exp_stb);
    check($sformatf("v%0d_other_stb", idx), v.we ? rdb_m : wrb_m, 0);
    check($sformatf("v%0d_ack", idx),       v.who_b ? ackb_m : acka_m, exp_ack);
    check($sformatf("v%0d_other_ack", idx), v.who_b ? acka_m : ackb_m, 0);
    check($sformatf("v%0d_bus_addr", idx),  addr_s, v.addr);
    check($sformatf("v%0d_bus_din", idx),   din_s, v.wdata);
    check($sformatf("v%0d_n9", idx),        n9_s, v.exp_n9);
    check($sformatf("v%0d_a_rdata", idx),   o_ard, mod_rd[sel][0]);
    check($sformatf("v%0d_b_rdata", idx),   o_brd, mod_rd[sel][1]);
    check($sformatf("v%0d_grant_b", idx),   o_gb, v.who_b);
  endtask

  initial begin
    int   nack;
    int   idle;
    int   ack_cyc [4];
    logic [3:0] order;
    logic ack_seen;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'h0A, 64'h0, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'h02, 64'hAAAA_AAAA_5555_5555, 32'h0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, REG_MAIN_RESET_HOLD, 64'h1111_2222_3333_4444, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, REG_KLIM, 64'h0, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 5'h1F, 64'h0123_4567_89AB_CDEF, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 5'h10, 64'hFEDC_BA98_7654_3210, 32'h0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 5'h05, 64'h0, 32'h8765_4321, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 5'h1E, 64'h0F0F_F0F0_0F0F_F0F0, 32'h0, 1'b0};
    for (int s = 0; s < 2; s++) for (int w = 0; w < 2; w++) mod_rd[s][w] = 32'd0;

    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_wrb", o_wrb, 1);   check("rst_rdb", o_rdb, 1);
    check("rst_addr", o_addr, 0); check("rst_din", o_din, 0);
    check("rst_n9", o_n9, 0);     check("rst_acks", {o_aack, o_back}, 0);
    check("rst_rdata", {o_ard, o_brd}, 0);
    check("rst_busy", o_busy, 0); check("rst_grant_b", o_gb, 1);
    reset = 1'b0;
    @(posedge sysclk);
    @(negedge sysclk);
    check("idle_busy", o_busy, 0);

    sel = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i], 7, 16'h000C, 16'h0010);
    sel = 1'b1;
    for (int i = 6; i < 8; i++) run_vec(i, vecs[i], 5, 16'h0002, 16'h0004);

    // Reset lands in the middle of a write strobe
    sel = 1'b0;
    a_we = 1'b1; a_dbl = 1'b0; a_addr = 5'h09; a_wdata = 64'h7777_8888_9999_AAAA;
    a_req = 1'b1;
    repeat (2) begin
      @(posedge sysclk);
      @(negedge sysclk);
    end
    check("mid_pre_wrb", o_wrb, 0);
    #2 reset = 1'b1;
    #1 check("mid_async_wrb", o_wrb, 1);
    a_req = 1'b0;
    @(negedge sysclk);
    check("mid_rdb", o_rdb, 1);    check("mid_addr", o_addr, 0);
    check("mid_din", o_din, 0);    check("mid_n9", o_n9, 0);
    check("mid_acks", {o_aack, o_back}, 0);
    check("mid_rdata", {o_ard, o_brd}, 0);
    check("mid_busy", o_busy, 0);  check("mid_grant_b", o_gb, 1);
    for (int s = 0; s < 2; s++) for (int w = 0; w < 2; w++) mod_rd[s][w] = 32'd0;
    @(negedge sysclk);
    reset = 1'b0;
    ack_seen = 1'b0;
    repeat (8) begin
      @(negedge sysclk);
      ack_seen = ack_seen | o_aack | o_back;
    end
    check("mid_no_ack", ack_seen, 0);

    // Both requesters held high: grants must alternate starting with A
    a_we = 1'b1; a_dbl = 1'b1; a_addr = 5'h03; a_wdata = 64'h0000_1111_2222_3333;
    b_we = 1'b0; b_dbl = 1'b0; b_addr = 5'h04;
    bus_dout = 32'h5A5A_A5A5;
    a_req = 1'b1; b_req = 1'b1;
    nack = 0; idle = 0; order = 4'b0;
    for (int k = 0; k < 4; k++) ack_cyc[k] = 0;
    for (int c = 1; c <= 40 && nack < 4; c++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      if (nack > 0 && !o_busy) idle++;
      if (o_aack || o_back) begin
        ack_cyc[nack] = c;
        order[nack]   = o_back;
        nack++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("tie_ack_count", nack, 4);
    check("tie_order", order, 4'b1010);
    check("tie_first_ack", ack_cyc[0], 4);
    check("tie_gap1", ack_cyc[1] - ack_cyc[0], 5);
    check("tie_gap2", ack_cyc[2] - ack_cyc[1], 5);
    check("tie_gap3", ack_cyc[3] - ack_cyc[2], 5);
    check("tie_idle_cycles", idle, 3);
    repeat (3) @(negedge sysclk);
    check("tie_b_rdata", o_brd, 32'h5A5A_A5A5);
    check("tie_a_rdata", o_ard, 32'h0);
    check("tie_idle_after", o_busy, 0);
    check("no_strobe_overlap", overlap_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
